hex_scan_display: RTL and testbench



---
 rtl/seg7_pkg.sv | 33 +++
 rtl/scan_timer.sv | 36 +++
 rtl/hex_scan_display.sv | 71 +++++++
 tb/tb_hex_scan_display.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment constants, hex decode table and width helpers
package seg7_pkg;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
  function automatic int width_of(input int v);
    return clog2(v) < 1 ? 1 : clog2(v);
  endfunction
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h18;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction
endpackage

// File: rtl/scan_timer.sv
// scan_timer: slot prescaler, digit slot counter and start-of-slot blank flag
module scan_timer import seg7_pkg::*; #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV = 50000,
  parameter int BLANK_CYCLES = 64,
  localparam int SW = width_of(NUM_DIGITS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  output logic [SW-1:0] slot_o,
  output logic          blank_o
);
  localparam int PW = width_of(CLK_DIV);
  logic [PW-1:0] pre_q, pre_d;
  logic [SW-1:0] slot_q, slot_d;
  logic wrap;
  // advance the prescaler; step the slot on prescaler wrap; hold both at 0 while disabled
  always_comb begin
    wrap = pre_q == PW'(CLK_DIV - 1);
    pre_d = (!en_i || wrap) ? '0 : pre_q + 1'b1;
    slot_d = !en_i ? '0 : !wrap ? slot_q : slot_q == SW'(NUM_DIGITS - 1) ? '0 : slot_q + 1'b1;
  end
  // timer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      slot_q <= '0;
    end else begin
      pre_q <= pre_d;
      slot_q <= slot_d;
    end
  end
  assign slot_o = slot_q;
  assign blank_o = pre_q < PW'(BLANK_CYCLES);
endmodule

// File: rtl/hex_scan_display.sv
// hex_scan_display: multiplexed common-anode 7-segment driver with blanking, LZ suppression, DP and blink
module hex_scan_display import seg7_pkg::*; #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV = 50000,
  parameter int BLANK_CYCLES = 64,
  parameter int BLINK_DIV = 25000000,
  localparam int SW = width_of(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable_i,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   blink_i,
  input  logic                    lz_sup_i,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic [SW-1:0]           slot_o
);
  localparam int BW = width_of(BLINK_DIV);
  logic [4*NUM_DIGITS-1:0] value_q, upper;
  logic [NUM_DIGITS-1:0] dp_q, blink_q, onehot, an_q, an_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic phase_q, phase_d, bwrap, blank, dark;
  logic [6:0] seg_q, seg_d;
  logic dpo_q, dpo_d;
  scan_timer #(.NUM_DIGITS(NUM_DIGITS), .CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK_CYCLES)) u_timer (
    .clk(clk), .rst_n(rst_n), .en_i(enable_i), .slot_o(slot_o), .blank_o(blank)
  );
  // blink phase timing and per-slot digit selection/darkening decision
  always_comb begin
    bwrap = bcnt_q == BW'(BLINK_DIV - 1);
    bcnt_d = (!enable_i || bwrap) ? '0 : bcnt_q + 1'b1;
    phase_d = enable_i && (phase_q ^ bwrap);
    upper = value_q >> {slot_o, 2'b00};
    onehot = NUM_DIGITS'(1) << slot_o;
    dark = blank || !enable_i || ((|(blink_q & onehot)) && phase_q) || (lz_sup_i && slot_o != '0 && upper == '0);
    an_d = dark ? '1 : ~onehot;
    seg_d = dark ? SEG_OFF : hex_to_seg(upper[3:0]);
    dpo_d = dark || !(|(dp_q & onehot));
  end
  // latch display contents and blink state; register pin outputs one cycle behind state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      dp_q <= '0;
      blink_q <= '0;
      bcnt_q <= '0;
      phase_q <= 1'b0;
      an_q <= '1;
      seg_q <= SEG_OFF;
      dpo_q <= 1'b1;
    end else begin
      if (load_i) begin
        value_q <= value_i;
        dp_q <= dp_i;
        blink_q <= blink_i;
      end
      bcnt_q <= bcnt_d;
      phase_q <= phase_d;
      an_q <= an_d;
      seg_q <= seg_d;
      dpo_q <= dpo_d;
    end
  end
  assign an_o = an_q;
  assign seg_o = seg_q;
  assign dp_o = dpo_q;
endmodule

// File: tb/tb_hex_scan_display.sv
// tb_hex_scan_display: randomized and directed checks against a cycle-count based display model
module tb_hex_scan_display;
  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  localparam logic [15:0] DARK = {8'hFF, 7'h7F, 1'b1};
  logic clk = 0, rst_n = 0;
  logic en = 0, ld = 0, lz = 0;
  logic [15:0] val = 0;
  logic [3:0] dpi = 0, bli = 0;
  logic [6:0] seg4;
  logic dpo4;
  logic [3:0] an4;
  logic [1:0] slot4;
  logic en1 = 1, ld1 = 0, lz1 = 0, dpi1 = 0, bli1 = 0;
  logic [3:0] val1 = 0;
  logic [6:0] seg1;
  logic dpo1, an1, slot1;
  int n_cmp = 0, n_err = 0;
  int t4 = 0, t1 = 0;
  logic [15:0] mv4 = 0;
  logic [3:0] md4 = 0, mb4 = 0, mv1 = 0;
  logic md1 = 0, mb1 = 0;
  logic [13:0] x4;
  logic [9:0] x1;

  always #5 clk = ~clk;

  hex_scan_display #(.NUM_DIGITS(4), .CLK_DIV(8), .BLANK_CYCLES(1), .BLINK_DIV(64)) dut4 (
    .clk(clk), .rst_n(rst_n), .enable_i(en), .load_i(ld), .value_i(val), .dp_i(dpi),
    .blink_i(bli), .lz_sup_i(lz), .seg_o(seg4), .dp_o(dpo4), .an_o(an4), .slot_o(slot4)
  );
  hex_scan_display #(.NUM_DIGITS(1), .CLK_DIV(8), .BLANK_CYCLES(1), .BLINK_DIV(64)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable_i(en1), .load_i(ld1), .value_i(val1), .dp_i(dpi1),
    .blink_i(bli1), .lz_sup_i(lz1), .seg_o(seg1), .dp_o(dpo1), .an_o(an1), .slot_o(slot1)
  );

  // t = clock edges since scanning (re)started; returns {an[7:0], seg, dp}
  function automatic logic [15:0] mdl(int n, int t, logic [31:0] v, logic [7:0] dv, logic [7:0] bv, logic lzs, logic e);
    int pre, s;
    bit ph, z;
    pre = t % 8;
    s = (t / 8) % n;
    ph = ((t / 64) % 2) == 1;
    z = 1;
    for (int k = s; k < n; k++) if (v[4*k +: 4] != 4'h0) z = 0;
    if (pre < 1 || !e || (bv[s] && ph) || (lzs && s != 0 && z)) return DARK;
    return {~(8'd1 << s), SEG[v[4*s +: 4]], ~dv[s]};
  endfunction

  task automatic step();
    logic [15:0] r4, r1;
    r4 = rst_n ? mdl(4, t4, {16'h0, mv4}, {4'h0, md4}, {4'h0, mb4}, lz, en) : DARK;
    r1 = rst_n ? mdl(1, t1, {28'h0, mv1}, {7'h0, md1}, {7'h0, mb1}, lz1, en1) : DARK;
    @(posedge clk);
    if (!rst_n) begin
      t4 = 0; mv4 = 0; md4 = 0; mb4 = 0;
      t1 = 0; mv1 = 0; md1 = 0; mb1 = 0;
    end else begin
      t4 = en ? t4 + 1 : 0;
      if (ld) begin mv4 = val; md4 = dpi; mb4 = bli; end
      t1 = en1 ? t1 + 1 : 0;
      if (ld1) begin mv1 = val1; md1 = dpi1; mb1 = bli1; end
    end
    x4 = {2'((t4 / 8) % 4), r4[11:0]};
    x1 = {1'b0, r1[8:0]};
    #1;
  endtask

  task automatic test_reset();
    step();
    n_cmp++;
    if ({slot4, an4, seg4, dpo4} !== 14'h3FFF >> 2)
      $display("FAIL reset_hold: got %h expected %h", {slot4, an4, seg4, dpo4}, 14'h0FFF);
    rst_n = 1; val = 16'h12AF; ld = 1;
    step();
    ld = 0; en = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++;
      if ({slot4, an4, seg4, dpo4} !== x4) begin
        n_err++;
        $display("FAIL reset_prerun cyc%0d: got %h expected %h", i, {slot4, an4, seg4, dpo4}, x4);
      end
    end
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if ({slot4, an4, seg4, dpo4} !== 14'h0FFF) begin
      n_err++;
      $display("FAIL reset_async: got %h expected %h", {slot4, an4, seg4, dpo4}, 14'h0FFF);
    end
    step();
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if ({slot4, an4, seg4, dpo4} !== x4) begin
        n_err++;
        $display("FAIL reset_release cyc%0d: got %h expected %h", i, {slot4, an4, seg4, dpo4}, x4);
      end
    end
  endtask

  task automatic test_scan();
    val = 16'h12AF; dpi = 0; bli = 0; lz = 0; ld = 1; en = 0;
    step();
    ld = 0; en = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      n_cmp++;
      if ({slot4, an4, seg4, dpo4} !== x4) begin
        n_err++;
        $display("FAIL scan cyc%0d: got %h expected %h", i, {slot4, an4, seg4, dpo4}, x4);
      end
      if (t4 == 3) begin
        n_cmp++;
        if ({an4, seg4} !== {4'b1110, 7'h0E}) begin
          n_err++;
          $display("FAIL scan_digit0: got %h expected %h", {an4, seg4}, {4'b1110, 7'h0E});
        end
      end
    end
  endtask

  task automatic test_suppression();
    logic [15:0] vals [3] = '{16'h0030, 16'h0000, 16'h0000};
    for (int p = 0; p < 3; p++) begin
      lz = (p < 2); val = vals[p]; ld = 1;
      step();
      ld = 0;
      for (int i = 0; i < 34; i++) begin
        step();
        n_cmp++;
        if ({slot4, an4, seg4, dpo4} !== x4) begin
          n_err++;
          $display("FAIL lz_sup p%0d cyc%0d: got %h expected %h", p, i, {slot4, an4, seg4, dpo4}, x4);
        end
      end
    end
    lz = 0;
  endtask

  task automatic test_dp_blink();
    val = 16'h12AF; dpi = 4'b0100; bli = 4'b0001; ld = 1; en = 0;
    step();
    ld = 0; en = 1;
    for (int i = 0; i < 280; i++) begin
      step();
      n_cmp++;
      if ({slot4, an4, seg4, dpo4} !== x4) begin
        n_err++;
        $display("FAIL dp_blink cyc%0d: got %h expected %h", i, {slot4, an4, seg4, dpo4}, x4);
      end
    end
  endtask

  task automatic test_enable();
    bli = 0; dpi = 0; val = 16'h12AF; ld = 1;
    step();
    ld = 0;
    for (int i = 0; i < 64 && (t4 % 32) != 19; i++) step();
    n_cmp++;
    if ((t4 % 32) != 19) begin
      n_err++;
      $display("FAIL enable_reach_slot2: got t=%0d expected slot2 mid", t4);
    end
    en = 0;
    step();
    n_cmp++;
    if ({slot4, an4, seg4, dpo4} !== 14'h0FFF) begin
      n_err++;
      $display("FAIL enable_off: got %h expected %h", {slot4, an4, seg4, dpo4}, 14'h0FFF);
    end
    en = 1;
    for (int i = 0; i < 12; i++) begin
      step();
      n_cmp++;
      if ({slot4, an4, seg4, dpo4} !== x4) begin
        n_err++;
        $display("FAIL enable_restart cyc%0d: got %h expected %h", i, {slot4, an4, seg4, dpo4}, x4);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      ld = ($urandom_range(7) == 0);
      val = 16'($urandom);
      if ($urandom_range(3) == 0) val[15:8] = 8'h00;
      dpi = 4'($urandom);
      bli = 4'($urandom);
      if (i % 50 == 0) lz = 1'($urandom);
      en = ($urandom_range(99) != 0);
      step();
      n_cmp++;
      if ({slot4, an4, seg4, dpo4} !== x4) begin
        n_err++;
        $display("FAIL random cyc%0d: got %h expected %h", i, {slot4, an4, seg4, dpo4}, x4);
      end
    end
    ld = 0; en = 1; lz = 0;
  endtask

  task automatic test_decode();
    for (int n = 0; n < 16; n++) begin
      val1 = 4'(n); dpi1 = 1'($urandom); ld1 = 1;
      step();
      ld1 = 0;
      for (int i = 0; i < 8; i++) begin
        step();
        n_cmp++;
        if ({slot1, an1, seg1, dpo1} !== x1) begin
          n_err++;
          $display("FAIL decode nib%0h cyc%0d: got %h expected %h", n, i, {slot1, an1, seg1, dpo1}, x1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_suppression();
    test_dp_blink();
    test_enable();
    test_random();
    test_decode();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
